int_priority_ctrl: RTL and testbench
====================================

INT_PRIORITY_CTRL -- requirements
Module: int_priority_ctrl

Interface
REQ-001 SHALL have parameter NUM_INT, default 4, meaning the number of interrupt channels (legal 2..8); channel 0 has the highest priority.
REQ-002 SHALL have parameter NMI_EN, default 1, meaning channel 0 ignores EI and the mask when set.
REQ-003 SHALL have derived parameter IDX_W, default $clog2(NUM_INT), meaning the channel index width.
REQ-004 SHALL have one clock; reset is asynchronous and active-low (CLK, RESET_N).
REQ-005 CLK  in  1  system clock, all state on rising edge.
REQ-006 RESET_N  in  1  asynchronous active-low reset.
REQ-007 COMMIT  in  1  instruction-commit strobe; gates all state except pending capture.
REQ-008 RETIX  in  1  RETI instruction decoded.
REQ-009 EIX / DIX  in  1 each  enable / disable global interrupts.
REQ-010 IMASK_LD  in  1  load channel mask.
REQ-011 IMASK_IN  in  NUM_INT  new mask, 1 = channel enabled.
REQ-012 INT_REQ  in  NUM_INT  raw interrupt request lines.
REQ-013 PC_NEXTX  out  3  PC next-source select code.
REQ-014 PC_LD_INT  out  NUM_INT  one-hot "save return PC for channel i" strobe.
REQ-015 INT_IDX  out  IDX_W  channel index qualifying PC_NEXTX vector/return codes.
REQ-016 IN_SERVICE  out  NUM_INT  in-service bitmap.
REQ-017 INT_ACTIVE  out  1  OR of IN_SERVICE.

Function
REQ-018 Each CLK, independent of COMMIT: PEND[i] SHALL set on a rising edge of INT_REQ[i] (previous sample 0, current 1).
REQ-019 ELIG[i] = PEND[i] & (MASK[i]&EI | (i==0 & NMI_EN)) & no IN_SERVICE[j] for j<=i; only a strictly higher priority preempts.
REQ-020 FSM states RUN, VEC, RETI; evaluated and advanced only on COMMIT; without COMMIT all outputs hold.
REQ-021 On COMMIT with RETIX and IN_SERVICE!=0: go to RETI; k = lowest set IN_SERVICE bit; clear IN_SERVICE[k]; INT_IDX=k; PC_NEXTX=PC_NEXTX_INTR; PC_LD_INT=0.
REQ-022 On COMMIT otherwise, with any ELIG: go to VEC; k = lowest ELIG index; set IN_SERVICE[k]; clear PEND[k]; INT_IDX=k; PC_NEXTX=PC_NEXTX_INTV; PC_LD_INT=one-hot(k).
REQ-023 On COMMIT otherwise: go to RUN; PC_NEXTX=PC_NEXTX_NEXT; PC_LD_INT=0; INT_IDX holds.
REQ-024 RETIX and ELIG on the same COMMIT: RETIX wins; the request stays pending and vectors on the next COMMIT (re-evaluated against the reduced IN_SERVICE).
REQ-025 RETIX with IN_SERVICE==0 SHALL be ignored and treated as REQ-023.
REQ-026 VEC and RETI SHALL last exactly one committed cycle; the next COMMIT applies REQ-021..023 again, so back-to-back VEC/RETI are legal.
REQ-027 EI: on COMMIT, EIX sets and DIX clears; EIX wins if both are asserted; the new value affects ELIG from the next COMMIT.
REQ-028 MASK SHALL load IMASK_IN on COMMIT & IMASK_LD and take effect on the next COMMIT.
REQ-029 A PEND set in the same CLK as the PEND clear for the same channel SHALL remain set (set wins).
REQ-030 All outputs SHALL be registered with a latency of one COMMIT from decision to output.

Reset
REQ-031 RESET_N low SHALL force: state RUN; PC_NEXTX=PC_NEXTX_NEXT; PC_LD_INT=0; INT_IDX=0; IN_SERVICE=0; PEND=0; EI=0; MASK=0; edge-sample register=0.
REQ-032 A request held high through reset release SHALL latch PEND on the first CLK after release.
REQ-033 Reset mid-service SHALL discard all nesting and pending state without generating a RETI.

Structure
REQ-034 The shared constants include SHALL hold INT_STATE_RUN/VEC/RETI and the new codes PC_NEXTX_INTV and PC_NEXTX_INTR, each distinct from the existing PC_NEXTX codes; PC_NEXTX_NEXT is reused.
REQ-035 A parametrised sub-module int_prio_enc (lowest-set-bit index plus a valid flag, width NUM_INT) SHALL be used for both ELIG and IN_SERVICE selection.

Verification (NUM_INT=4, NMI_EN=1, COMMIT=1 unless stated)
REQ-036 EIX, MASK=4'b1111, pulse INT_REQ[2] -> next COMMIT: PC_NEXTX=INTV, INT_IDX=2, PC_LD_INT=4'b0100, IN_SERVICE=4'b0100; following COMMIT: PC_NEXTX=NEXT.
REQ-037 Channel 2 in service, pulse INT_REQ[3] then INT_REQ[1] -> only channel 1 vectors, giving IN_SERVICE=4'b0110; RETIX clears bit 1 with INT_IDX=1 and PC_NEXTX=INTR; channel 3 stays pending until both returns complete.
REQ-038 EI=0, MASK=0, pulse INT_REQ[0] -> vectors to channel 0 (NMI); the same pulse on channel 1 -> PEND[1]=1 with no vector until EIX and MASK[1]=1.
REQ-039 Channel 1 in service; same COMMIT has RETIX and pending channel 2 -> RETI with INT_IDX=1 first, then VEC with INT_IDX=2 on the next COMMIT.
REQ-040 Pulse INT_REQ[1] while COMMIT=0 for 5 cycles -> outputs hold throughout; vector occurs on the first COMMIT; RESET_N low while IN_SERVICE=4'b0011 -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/int_priority_ctrl_pkg.sv
// Shared constants for the interrupt priority controller.
// Holds the controller FSM state encoding and the PC next-source select codes.
// PC_NEXTX_NEXT and the branch/jump/return codes are the pre-existing PC mux
// selects; INTV (jump to vector) and INTR (interrupt return) are the new ones.
package int_priority_ctrl_pkg;

  localparam int unsigned PC_NEXTX_W = 3;

  localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_NEXT = 3'd0;
  localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_BR   = 3'd1;
  localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_JMP  = 3'd2;
  localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_RET  = 3'd3;
  localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_INTV = 3'd4;
  localparam logic [PC_NEXTX_W-1:0] PC_NEXTX_INTR = 3'd5;

  typedef enum logic [1:0] {
    INT_STATE_RUN  = 2'd0,
    INT_STATE_VEC  = 2'd1,
    INT_STATE_RETI = 2'd2
  } int_state_e;

endpackage

// File: rtl/int_priority_ctrl_prio_enc.sv
// Lowest-set-bit priority encoder.
// Ports:
//   i_vec   - input bit vector, bit 0 has highest priority
//   o_idx   - index of the lowest set bit (0 when none set)
//   o_valid - at least one bit of i_vec is set
module int_prio_enc #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  always_comb begin
    o_idx = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = IDX_W'(i);
      end
    end
  end

  assign o_valid = |i_vec;

endmodule

// File: rtl/int_priority_ctrl.sv
// Nested priority interrupt controller.
// Captures request edges into pending bits every clock, and on each instruction
// commit decides between interrupt return, vectoring to the highest-priority
// eligible channel, or normal sequencing. All decisions appear on the outputs
// one commit later.
// Ports:
//   i_clk, i_reset_n - clock, asynchronous active-low reset
//   i_commit         - instruction-commit strobe; gates everything but pending capture
//   i_retix          - RETI instruction decoded
//   i_eix / i_dix    - enable / disable global interrupts
//   i_imask_ld       - load channel mask from i_imask_in
//   i_int_req        - raw request lines
//   o_pc_nextx       - PC next-source select
//   o_pc_ld_int      - one-hot save-return-PC strobe
//   o_int_idx        - channel index qualifying the vector/return codes
//   o_in_service     - in-service bitmap
//   o_int_active     - any channel in service
module int_priority_ctrl
  import int_priority_ctrl_pkg::*;
#(
  parameter int unsigned NUM_INT = 4,
  parameter bit          NMI_EN  = 1'b1,
  parameter int unsigned IDX_W   = $clog2(NUM_INT)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_commit,
  input  logic                  i_retix,
  input  logic                  i_eix,
  input  logic                  i_dix,
  input  logic                  i_imask_ld,
  input  logic [NUM_INT-1:0]    i_imask_in,
  input  logic [NUM_INT-1:0]    i_int_req,
  output logic [PC_NEXTX_W-1:0] o_pc_nextx,
  output logic [NUM_INT-1:0]    o_pc_ld_int,
  output logic [IDX_W-1:0]      o_int_idx,
  output logic [NUM_INT-1:0]    o_in_service,
  output logic                  o_int_active
);

  int_state_e         r_state;
  logic [NUM_INT-1:0] r_req_smp;
  logic [NUM_INT-1:0] r_pend;
  logic               r_ei;
  logic [NUM_INT-1:0] r_mask;
  logic [NUM_INT-1:0] r_pc_ld_int;
  logic [IDX_W-1:0]   r_int_idx;
  logic [NUM_INT-1:0] r_in_service;

  int_state_e         w_state_d;
  logic [NUM_INT-1:0] w_pc_ld_d;
  logic [IDX_W-1:0]   w_int_idx_d;
  logic [NUM_INT-1:0] w_in_service_d;
  logic [NUM_INT-1:0] w_pend_clr;
  logic [NUM_INT-1:0] w_elig;
  logic [IDX_W-1:0]   w_elig_idx;
  logic               w_elig_vld;
  logic [IDX_W-1:0]   w_svc_idx;
  logic               w_svc_vld;

  // A channel is eligible only if nothing at its own or higher priority is in
  // service, so an in-service channel cannot re-enter and equal priority never preempts.
  always_comb begin
    logic blocked;
    blocked = 1'b0;
    w_elig  = '0;
    for (int i = 0; i < NUM_INT; i++) begin
      blocked   = blocked | r_in_service[i];
      w_elig[i] = r_pend[i] & ((r_mask[i] & r_ei) | ((i == 0) & NMI_EN)) & ~blocked;
    end
  end

  int_prio_enc #(
    .WIDTH (NUM_INT),
    .IDX_W (IDX_W)
  ) u_elig_enc (
    .i_vec   (w_elig),
    .o_idx   (w_elig_idx),
    .o_valid (w_elig_vld)
  );

  int_prio_enc #(
    .WIDTH (NUM_INT),
    .IDX_W (IDX_W)
  ) u_svc_enc (
    .i_vec   (r_in_service),
    .o_idx   (w_svc_idx),
    .o_valid (w_svc_vld)
  );

  // Decision logic; only applied to the registers on a commit.
  always_comb begin
    w_state_d      = INT_STATE_RUN;
    w_pc_ld_d      = '0;
    w_int_idx_d    = r_int_idx;
    w_in_service_d = r_in_service;
    w_pend_clr     = '0;
    if (i_retix && w_svc_vld) begin
      w_state_d                 = INT_STATE_RETI;
      w_int_idx_d               = w_svc_idx;
      w_in_service_d[w_svc_idx] = 1'b0;
    end else if (w_elig_vld) begin
      w_state_d                  = INT_STATE_VEC;
      w_int_idx_d                = w_elig_idx;
      w_in_service_d[w_elig_idx] = 1'b1;
      w_pend_clr[w_elig_idx]     = 1'b1;
      w_pc_ld_d                  = NUM_INT'(1) << w_elig_idx;
    end
  end

  // Edge capture runs every clock; a new edge beats a same-cycle clear.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_req_smp <= '0;
      r_pend    <= '0;
    end else begin
      r_req_smp <= i_int_req;
      r_pend    <= (r_pend & ~(i_commit ? w_pend_clr : '0)) | (i_int_req & ~r_req_smp);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= INT_STATE_RUN;
      r_pc_ld_int  <= '0;
      r_int_idx    <= '0;
      r_in_service <= '0;
      r_ei         <= 1'b0;
      r_mask       <= '0;
    end else if (i_commit) begin
      r_state      <= w_state_d;
      r_pc_ld_int  <= w_pc_ld_d;
      r_int_idx    <= w_int_idx_d;
      r_in_service <= w_in_service_d;
      r_ei         <= i_eix ? 1'b1 : (i_dix ? 1'b0 : r_ei);
      if (i_imask_ld) begin
        r_mask <= i_imask_in;
      end
    end
  end

  always_comb begin
    o_pc_nextx = PC_NEXTX_NEXT;
    unique case (r_state)
      INT_STATE_VEC:  o_pc_nextx = PC_NEXTX_INTV;
      INT_STATE_RETI: o_pc_nextx = PC_NEXTX_INTR;
      default:        o_pc_nextx = PC_NEXTX_NEXT;
    endcase
  end

  assign o_pc_ld_int  = r_pc_ld_int;
  assign o_int_idx    = r_int_idx;
  assign o_in_service = r_in_service;
  assign o_int_active = |r_in_service;

endmodule

// File: tb/tb_int_priority_ctrl.sv
// Directed table-driven bench for int_priority_ctrl (NUM_INT=4, NMI_EN=1).
module tb_int_priority_ctrl;

  localparam logic [2:0] N = 3'd0;  // next
  localparam logic [2:0] V = 3'd4;  // vector
  localparam logic [2:0] R = 3'd5;  // interrupt return

  logic       clk = 1'b0;
  logic       rst_n;
  logic       commit, retix, eix, dix, imask_ld;
  logic [3:0] imask_in, int_req;
  logic [2:0] pc_nextx;
  logic [3:0] pc_ld_int;
  logic [1:0] int_idx;
  logic [3:0] in_service;
  logic       int_active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_priority_ctrl #(
    .NUM_INT (4),
    .NMI_EN  (1'b1)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_commit     (commit),
    .i_retix      (retix),
    .i_eix        (eix),
    .i_dix        (dix),
    .i_imask_ld   (imask_ld),
    .i_imask_in   (imask_in),
    .i_int_req    (int_req),
    .o_pc_nextx   (pc_nextx),
    .o_pc_ld_int  (pc_ld_int),
    .o_int_idx    (int_idx),
    .o_in_service (in_service),
    .o_int_active (int_active)
  );

  typedef struct {
    logic       commit;
    logic       retix;
    logic       eix;
    logic       dix;
    logic       ld;
    logic [3:0] mask;
    logic [3:0] req;
    logic [2:0] e_pc;
    logic [3:0] e_ld;
    logic [1:0] e_idx;
    logic [3:0] e_isv;
  } vec_t;

  vec_t tbl[44];

  task automatic check_outs(input string name, input logic [2:0] e_pc, input logic [3:0] e_ld,
                            input logic [1:0] e_idx, input logic [3:0] e_isv);
    checks++;
    if (pc_nextx !== e_pc) begin
      errors++;
      $display("FAIL %s pc_nextx got %0d want %0d", name, pc_nextx, e_pc);
    end
    checks++;
    if (pc_ld_int !== e_ld) begin
      errors++;
      $display("FAIL %s pc_ld_int got %b want %b", name, pc_ld_int, e_ld);
    end
    checks++;
    if (int_idx !== e_idx) begin
      errors++;
      $display("FAIL %s int_idx got %0d want %0d", name, int_idx, e_idx);
    end
    checks++;
    if (in_service !== e_isv) begin
      errors++;
      $display("FAIL %s in_service got %b want %b", name, in_service, e_isv);
    end
    checks++;
    if (int_active !== (|e_isv)) begin
      errors++;
      $display("FAIL %s int_active got %b want %b", name, int_active, |e_isv);
    end
  endtask

  task automatic drive(input logic c, input logic rt, input logic e, input logic d,
                       input logic l, input logic [3:0] m, input logic [3:0] rq);
    commit = c; retix = rt; eix = e; dix = d; imask_ld = l; imask_in = m; int_req = rq;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          cm rt ei di ld mask   req     pc  ld     idx   isv
    tbl[0]  = '{1, 0, 1, 0, 1, 4'hF, 4'h0,   N, 4'h0, 2'd0, 4'h0};
    tbl[1]  = '{1, 0, 0, 0, 0, 4'h0, 4'h4,   N, 4'h0, 2'd0, 4'h0};
    tbl[2]  = '{1, 0, 0, 0, 0, 4'h0, 4'h0,   V, 4'h4, 2'd2, 4'h4};
    tbl[3]  = '{1, 0, 0, 0, 0, 4'h0, 4'h0,   N, 4'h0, 2'd2, 4'h4};
    tbl[4]  = '{1, 0, 0, 0, 0, 4'h0, 4'h8,   N, 4'h0, 2'd2, 4'h4};
    tbl[5]  = '{1, 0, 0, 0, 0, 4'h0, 4'h2,   N, 4'h0, 2'd2, 4'h4};
    tbl[6]  = '{1, 0, 0, 0, 0, 4'h0, 4'h0,   V, 4'h2, 2'd1, 4'h6};
    tbl[7]  = '{1, 0, 0, 0, 0, 4'h0, 4'h0,   N, 4'h0, 2'd1, 4'h6};
    tbl[8]  = '{1, 1, 0, 0, 0, 4'h0, 4'h0,   R, 4'h0, 2'd1, 4'h4};
    tbl[9]  = '{1, 0, 0, 0, 0, 4'h0, 4'h0,   N, 4'h0, 2'd1, 4'h4};
    tbl[10] = '{1, 1, 0, 0, 0, 4'h0, 4'h0,   R, 4'h0, 2'd2, 4'h0};
    tbl[11] = '{1, 0, 0, 0, 0, 4'h0, 4'h0,   V, 4'h8, 2'd3, 4'h8};
    tbl[12] = '{1, 1, 0, 0, 0, 4'h0, 4'h0,   R, 4'h0, 2'd3, 4'h0};
    tbl[13] = '{1, 0, 0, 0, 0, 4'h0, 4'h0,   N, 4'h0, 2'd3, 4'h0};
    tbl[14] = '{1, 0, 0, 1, 1, 4'h0, 4'h0,   N, 4'h0, 2'd3, 4'h0};
    tbl[15] = '{1, 0, 0, 0, 0, 4'h0, 4'h1,   N, 4'h0, 2'd3, 4'h0};
    tbl[16] = '{1, 0, 0, 0, 0, 4'h0, 4'h0,   V, 4'h1, 2'd0, 4'h1};
    tbl[17] = '{1, 1, 0, 0, 0, 4'h0, 4'h0,   R, 4'h0, 2'd0, 4'h0};
    tbl[18] = '{1, 0, 0, 0, 0, 4'h0, 4'h2,   N, 4'h0, 2'd0, 4'h0};
    tbl[19] = '{1, 0, 0, 0, 0, 4'h0, 4'h0,   N, 4'h0, 2'd0, 4'h0};
    tbl[20] = '{1, 0, 1, 0, 1, 4'h2, 4'h0,   N, 4'h0, 2'd0, 4'h0};
    tbl[21] = '{1, 0, 0, 0, 0, 4'h0, 4'h0,   V, 4'h2, 2'd1, 4'h2};
    tbl[22] = '{1, 0, 0, 0, 1, 4'h6, 4'h4,   N, 4'h0, 2'd1, 4'h2};
    tbl[23] = '{1, 1, 0, 0, 0, 4'h0, 4'h0,   R, 4'h0, 2'd1, 4'h0};
    tbl[24] = '{1, 0, 0, 0, 0, 4'h0, 4'h0,   V, 4'h4, 2'd2, 4'h4};
    tbl[25] = '{1, 1, 0, 0, 0, 4'h0, 4'h0,   R, 4'h0, 2'd2, 4'h0};
    tbl[26] = '{1, 0, 0, 0, 1, 4'hF, 4'h8,   N, 4'h0, 2'd2, 4'h0};
    tbl[27] = '{1, 0, 0, 0, 0, 4'h0, 4'h0,   V, 4'h8, 2'd3, 4'h8};
    tbl[28] = '{1, 0, 0, 0, 0, 4'h0, 4'h2,   N, 4'h0, 2'd3, 4'h8};
    // channel 1 eligible (preempts 3) but RETIX wins this commit
    tbl[29] = '{1, 1, 0, 0, 0, 4'h0, 4'h0,   R, 4'h0, 2'd3, 4'h0};
    tbl[30] = '{1, 0, 0, 0, 0, 4'h0, 4'h0,   V, 4'h2, 2'd1, 4'h2};
    tbl[31] = '{1, 1, 0, 0, 0, 4'h0, 4'h0,   R, 4'h0, 2'd1, 4'h0};
    tbl[32] = '{1, 0, 0, 0, 0, 4'h0, 4'h2,   N, 4'h0, 2'd1, 4'h0};
    tbl[33] = '{0, 0, 0, 0, 0, 4'h0, 4'h0,   N, 4'h0, 2'd1, 4'h0};
    // new edge on channel 1 in the same clock its pending bit is consumed
    tbl[34] = '{1, 0, 0, 0, 0, 4'h0, 4'h2,   V, 4'h2, 2'd1, 4'h2};
    tbl[35] = '{1, 1, 0, 0, 0, 4'h0, 4'h0,   R, 4'h0, 2'd1, 4'h0};
    tbl[36] = '{1, 0, 0, 0, 0, 4'h0, 4'h0,   V, 4'h2, 2'd1, 4'h2};
    tbl[37] = '{1, 1, 0, 0, 0, 4'h0, 4'h0,   R, 4'h0, 2'd1, 4'h0};
    tbl[38] = '{1, 0, 0, 0, 0, 4'h0, 4'h0,   N, 4'h0, 2'd1, 4'h0};
    tbl[39] = '{1, 0, 0, 1, 0, 4'h0, 4'h0,   N, 4'h0, 2'd1, 4'h0};
    tbl[40] = '{1, 0, 1, 1, 0, 4'h0, 4'h0,   N, 4'h0, 2'd1, 4'h0};
    tbl[41] = '{1, 0, 0, 0, 0, 4'h0, 4'h4,   N, 4'h0, 2'd1, 4'h0};
    tbl[42] = '{1, 0, 0, 0, 0, 4'h0, 4'h0,   V, 4'h4, 2'd2, 4'h4};
    tbl[43] = '{1, 1, 0, 0, 0, 4'h0, 4'h0,   R, 4'h0, 2'd2, 4'h0};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 4'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", N, 4'h0, 2'd0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      drive(tbl[i].commit, tbl[i].retix, tbl[i].eix, tbl[i].dix, tbl[i].ld, tbl[i].mask,
            tbl[i].req);
      step();
      check_outs($sformatf("row%0d", i), tbl[i].e_pc, tbl[i].e_ld, tbl[i].e_idx, tbl[i].e_isv);
    end

    // Request pulse with no commit for 5 clocks: outputs hold, vector on first commit.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 4'h0, (i == 0) ? 4'h2 : 4'h0);
      step();
      check_outs($sformatf("hold%0d", i), R, 4'h0, 2'd2, 4'h0);
    end
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 4'h0, 4'h0);
    step();
    check_outs("hold_vec", V, 4'h2, 2'd1, 4'h2);

    // Nest NMI over channel 1, then reset asynchronously mid-service.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 4'h0, 4'h1);
    step();
    check_outs("nest_pend0", N, 4'h0, 2'd1, 4'h2);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 4'h0, 4'h0);
    step();
    check_outs("nest_vec0", V, 4'h1, 2'd0, 4'h3);
    #2;
    int_req = 4'h1;  // held high through reset
    rst_n   = 1'b0;
    #1;
    check_outs("async_rst", N, 4'h0, 2'd0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_outs("post_rst0", N, 4'h0, 2'd0, 4'h0);
    @(negedge clk);
    retix = 1'b1;  // nothing in service: must be ignored
    step();
    check_outs("post_rst1", V, 4'h1, 2'd0, 4'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached without finishing");
    $fatal(1, "timeout");
  end

endmodule
